// File: rtl/golden_nonce_pkg.sv
// Shared widths, FSM state type and helpers for golden_nonce_queue.
package golden_nonce_pkg;

   localparam int unsigned NONCE_W = 32;
   localparam int unsigned DROP_W  = 8;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_BUSY,
      WAIT_DONE
   } gnq_state_t;

   // Increment that sticks at all-ones.
   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      return (&v) ? v : v + DROP_W'(1);
   endfunction

endpackage

// File: rtl/gnq_fifo.sv
// Synchronous FIFO for golden nonces: push/pop/flush, level, full/empty, head of registered storage.
module gnq_fifo
   import golden_nonce_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic                 pop,
   input  logic                 flush,
   input  logic [NONCE_W-1:0]   wdata,
   output logic [NONCE_W-1:0]   head,
   output logic [DEPTH_LOG2:0]  level,
   output logic                 full,
   output logic                 empty
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2 + 1)'(1);

   logic [NONCE_W-1:0]  mem [DEPTH];
   logic [DEPTH_LOG2:0] wr_ptr;
   logic [DEPTH_LOG2:0] rd_ptr;
   logic                do_push;
   logic                do_pop;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                    (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
   assign level   = wr_ptr - rd_ptr;
   assign head    = mem[rd_ptr[DEPTH_LOG2-1:0]];
   assign do_pop  = pop && !empty;
   assign do_push = push && !flush && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
   end

endmodule

// File: rtl/golden_nonce_queue.sv
// Queues golden nonces and hands them one word at a time to serial_transmit via send/busy.
// Optional `define NONCE_DEDUP_EN drops a push equal to the last accepted nonce.
module golden_nonce_queue
   import golden_nonce_pkg::*;
#(
   parameter int unsigned        DEPTH_LOG2        = 3,
   parameter logic [NONCE_W-1:0] NONCE_OFFSET      = '0,
   parameter bit                 FLUSH_ON_NEW_WORK = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 nonce_valid,
   input  logic [NONCE_W-1:0]   nonce,
   input  logic                 load_flag,
   input  logic                 tx_busy,
   output logic                 tx_send,
   output logic [NONCE_W-1:0]   tx_word,
   output logic [DEPTH_LOG2:0]  level,
   output logic [DROP_W-1:0]    drop_count
);

   gnq_state_t         state;
   logic               load_prev;
   logic [NONCE_W-1:0] adj;
   logic [NONCE_W-1:0] head;
   logic               full;
   logic               empty;
   logic               flush;
   logic               pop;
   logic               dup;
   logic               push;
   logic               drop;

   assign adj   = nonce - NONCE_OFFSET;
   assign flush = FLUSH_ON_NEW_WORK && (load_flag != load_prev);
   assign pop   = (state == IDLE) && !empty && !tx_busy;
   // A stale nonce in a flush cycle is neither queued nor counted as a drop.
   assign push  = nonce_valid && !flush && !dup && (!full || pop);
   assign drop  = nonce_valid && !flush && !dup && full && !pop;

`ifdef NONCE_DEDUP_EN
   logic [NONCE_W-1:0] last_nonce;
   logic               last_valid;

   assign dup = last_valid && (adj == last_nonce);

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         last_valid <= 1'b0;
      end else if (push) begin
         last_valid <= 1'b1;
         last_nonce <= adj;
      end
   end
`else
   assign dup = 1'b0;
`endif

   gnq_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata (adj),
      .head  (head),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         load_prev  <= load_flag;
         drop_count <= '0;
      end else begin
         load_prev <= load_flag;
         if (drop) drop_count <= sat_inc(drop_count);
      end
   end

   // Handshake FSM; a word already handed over is never disturbed by a flush.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         tx_send <= 1'b0;
         tx_word <= '0;
      end else begin
         tx_send <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pop) begin
                  tx_send <= 1'b1;
                  tx_word <= head;
                  state   <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: if (tx_busy)  state <= WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_golden_nonce_queue.sv
// Self-checking bench for golden_nonce_queue with a transmitter model and a queue-based reference.
module tb_golden_nonce_queue;

   localparam logic [31:0] OFFSET = 32'd4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        nonce_valid = 1'b0;
   logic [31:0] nonce = '0;
   logic        load_flag = 1'b0;
   logic        force_busy = 1'b0;
   logic        xmit_busy = 1'b0;
   logic        tx_busy;
   logic        tx_send;
   logic [31:0] tx_word;
   logic [3:0]  level;
   logic [7:0]  drop_count;

   assign tx_busy = force_busy | xmit_busy;
   always #5 clk = ~clk;

   golden_nonce_queue #(
      .DEPTH_LOG2        (3),
      .NONCE_OFFSET      (OFFSET),
      .FLUSH_ON_NEW_WORK (1'b1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .nonce_valid (nonce_valid),
      .nonce       (nonce),
      .load_flag   (load_flag),
      .tx_busy     (tx_busy),
      .tx_send     (tx_send),
      .tx_word     (tx_word),
      .level       (level),
      .drop_count  (drop_count)
   );

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   int busy_len = 40;
   int busy_cnt = 0;
   int fall_cyc = -1000;
   int send_while_busy = 0;
   int multi_send = 0;
   bit prev_send = 1'b0;
   logic [31:0] sent_words[$];
   int sent_cyc[$];
   int sent_gap[$];

   // Reference model: words expected on the wire in order, plus drop counter.
   logic [31:0] exp_q[$];
   int exp_drop = 0;
   logic [31:0] last_acc = '0;
   bit last_ok = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Transmitter: busy for busy_len cycles after each send.
   always @(negedge clk) begin
      if (tx_send) begin
         if (tx_busy) send_while_busy++;
         if (prev_send) multi_send++;
         sent_words.push_back(tx_word);
         sent_cyc.push_back(cyc);
         sent_gap.push_back(cyc - fall_cyc);
         busy_cnt = busy_len;
         xmit_busy = 1'b1;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) begin
            xmit_busy = 1'b0;
            fall_cyc = cyc;
         end
      end
      prev_send = tx_send;
   end

   function automatic void model_offer(input logic [31:0] raw, input bit pop_same);
      logic [31:0] w;
      w = raw - OFFSET;
`ifdef NONCE_DEDUP_EN
      if (last_ok && w == last_acc) return;
`endif
      if (exp_q.size() < 8 || pop_same) begin
         exp_q.push_back(w);
         last_acc = w;
         last_ok = 1'b1;
      end else if (exp_drop < 255) begin
         exp_drop++;
      end
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic push(input logic [31:0] raw, input bit pop_same);
      nonce = raw;
      nonce_valid = 1'b1;
      model_offer(raw, pop_same);
      step();
      nonce_valid = 1'b0;
   endtask

   task automatic wait_sends(input int n, input int budget);
      for (int i = 0; i < budget && sent_words.size() < n; i++) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      steps(2);
      checks++; if (tx_send !== 1'b0) $display("FAIL reset_tx_send got %b want 0", tx_send); else passes++;
      checks++; if (tx_word !== 32'h0) $display("FAIL reset_tx_word got %h want 0", tx_word); else passes++;
      checks++; if (level !== 4'd0) $display("FAIL reset_level got %0d want 0", level); else passes++;
      checks++; if (drop_count !== 8'd0) $display("FAIL reset_drop got %0d want 0", drop_count); else passes++;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      int n0, c;
      logic [31:0] w;
      busy_len = 6;
      n0 = sent_words.size();
      c = cyc;
      push(32'h0000_1234, 1'b0);
      wait_sends(n0 + 1, 20);
      checks++; if (sent_words.size() !== n0 + 1) $display("FAIL single_count got %0d want %0d", sent_words.size(), n0 + 1); else passes++;
      if (sent_words.size() == n0 + 1) begin
         w = exp_q.pop_front();
         checks++; if (sent_words[n0] !== w) $display("FAIL single_word got %h want %h", sent_words[n0], w); else passes++;
         checks++; if (sent_cyc[n0] !== c + 2) $display("FAIL single_latency got %0d want %0d", sent_cyc[n0] - c, 2); else passes++;
         steps(10);
         checks++; if (tx_word !== w) $display("FAIL single_hold got %h want %h", tx_word, w); else passes++;
      end
      checks++; if (level !== 4'd0) $display("FAIL single_level got %0d want 0", level); else passes++;
      checks++; if (multi_send !== 0) $display("FAIL single_pulse got %0d want 0", multi_send); else passes++;
   endtask

   task automatic test_back_to_back();
      int n0;
      logic [31:0] base, w;
      busy_len = 40;
      n0 = sent_words.size();
      base = $urandom;
      for (int i = 0; i < 3; i++) push(base + 32'(i * 7), 1'b0);
      wait_sends(n0 + 3, 400);
      checks++; if (sent_words.size() !== n0 + 3) $display("FAIL b2b_count got %0d want %0d", sent_words.size(), n0 + 3); else passes++;
      for (int i = n0; i < sent_words.size(); i++) begin
         w = exp_q.pop_front();
         checks++; if (sent_words[i] !== w) $display("FAIL b2b_word%0d got %h want %h", i - n0, sent_words[i], w); else passes++;
         checks++; if (sent_gap[i] < 1) $display("FAIL b2b_gap%0d got %0d want >=1", i - n0, sent_gap[i]); else passes++;
      end
      steps(45);
      checks++; if (level !== 4'd0) $display("FAIL b2b_level got %0d want 0", level); else passes++;
      checks++; if (send_while_busy !== 0) $display("FAIL b2b_busy_send got %0d want 0", send_while_busy); else passes++;
   endtask

   task automatic test_overflow();
      int n0;
      logic [31:0] base, w;
      force_busy = 1'b1;
      n0 = sent_words.size();
      base = $urandom;
      for (int i = 0; i < 10; i++) push(base + 32'(i), 1'b0);
      checks++; if (level !== 4'd8) $display("FAIL ovf_level got %0d want 8", level); else passes++;
      checks++; if (drop_count !== 8'(exp_drop)) $display("FAIL ovf_drop got %0d want %0d", drop_count, exp_drop); else passes++;
      busy_len = 5;
      force_busy = 1'b0;
      wait_sends(n0 + 8, 200);
      steps(20);
      checks++; if (sent_words.size() !== n0 + 8) $display("FAIL ovf_count got %0d want %0d", sent_words.size(), n0 + 8); else passes++;
      for (int i = n0; i < sent_words.size() && exp_q.size() > 0; i++) begin
         w = exp_q.pop_front();
         checks++; if (sent_words[i] !== w) $display("FAIL ovf_word%0d got %h want %h", i - n0, sent_words[i], w); else passes++;
      end
      checks++; if (level !== 4'd0) $display("FAIL ovf_drain got %0d want 0", level); else passes++;
   endtask

   task automatic test_flush();
      int n0;
      logic [31:0] base, w;
      busy_len = 30;
      n0 = sent_words.size();
      base = $urandom;
      for (int i = 0; i < 6; i++) push(base + 32'(i * 3), 1'b0);
      checks++; if (sent_words.size() !== n0 + 1) $display("FAIL flush_first got %0d want %0d", sent_words.size(), n0 + 1); else passes++;
      w = exp_q.pop_front();
      if (sent_words.size() > n0) begin
         checks++; if (sent_words[n0] !== w) $display("FAIL flush_word got %h want %h", sent_words[n0], w); else passes++;
      end
      checks++; if (level !== 4'd5) $display("FAIL flush_pre_level got %0d want 5", level); else passes++;
      load_flag = ~load_flag;
      exp_q.delete();
      last_ok = 1'b0;
      step();
      checks++; if (level !== 4'd0) $display("FAIL flush_level got %0d want 0", level); else passes++;
      steps(60);
      checks++; if (sent_words.size() !== n0 + 1) $display("FAIL flush_extra got %0d want %0d", sent_words.size(), n0 + 1); else passes++;
   endtask

   task automatic test_full_pop();
      int n0, d0;
      logic [31:0] base, w;
      force_busy = 1'b1;
      step();
      n0 = sent_words.size();
      d0 = exp_drop;
      base = $urandom;
      for (int i = 0; i < 8; i++) push(base + 32'(i), 1'b0);
      checks++; if (level !== 4'd8) $display("FAIL fullpop_fill got %0d want 8", level); else passes++;
      busy_len = 5;
      force_busy = 1'b0;
      push(base + 32'd100, 1'b1);
      checks++; if (level !== 4'd8) $display("FAIL fullpop_level got %0d want 8", level); else passes++;
      checks++; if (drop_count !== 8'(d0)) $display("FAIL fullpop_drop got %0d want %0d", drop_count, d0); else passes++;
      checks++; if (tx_send !== 1'b1) $display("FAIL fullpop_send got %b want 1", tx_send); else passes++;
      wait_sends(n0 + 9, 300);
      steps(20);
      checks++; if (sent_words.size() !== n0 + 9) $display("FAIL fullpop_count got %0d want %0d", sent_words.size(), n0 + 9); else passes++;
      for (int i = n0; i < sent_words.size() && exp_q.size() > 0; i++) begin
         w = exp_q.pop_front();
         checks++; if (sent_words[i] !== w) $display("FAIL fullpop_word%0d got %h want %h", i - n0, sent_words[i], w); else passes++;
      end
      checks++; if (level !== 4'd0) $display("FAIL fullpop_drain got %0d want 0", level); else passes++;
   endtask

   task automatic test_drop_saturate();
      int n0;
      logic [31:0] base, w;
      force_busy = 1'b1;
      n0 = sent_words.size();
      base = $urandom;
      for (int i = 0; i < 308; i++) push(base + 32'(i), 1'b0);
      checks++; if (drop_count !== 8'(exp_drop)) $display("FAIL sat_drop got %0d want %0d", drop_count, exp_drop); else passes++;
      checks++; if (level !== 4'd8) $display("FAIL sat_level got %0d want 8", level); else passes++;
      busy_len = 3;
      force_busy = 1'b0;
      wait_sends(n0 + 8, 200);
      steps(10);
      checks++; if (sent_words.size() !== n0 + 8) $display("FAIL sat_count got %0d want %0d", sent_words.size(), n0 + 8); else passes++;
      for (int i = n0; i < sent_words.size() && exp_q.size() > 0; i++) begin
         w = exp_q.pop_front();
         checks++; if (sent_words[i] !== w) $display("FAIL sat_word%0d got %h want %h", i - n0, sent_words[i], w); else passes++;
      end
   endtask

   task automatic test_dedup_and_reset();
      int n0, want;
      logic [31:0] base, w;
      busy_len = 8;
      n0 = sent_words.size();
      push(32'hDEAD_BEEF, 1'b0);
      push(32'hDEAD_BEEF, 1'b0);
      want = exp_q.size();
      wait_sends(n0 + want, 100);
      steps(30);
      checks++; if (sent_words.size() !== n0 + want) $display("FAIL dedup_count got %0d want %0d", sent_words.size(), n0 + want); else passes++;
      for (int i = n0; i < sent_words.size() && exp_q.size() > 0; i++) begin
         w = exp_q.pop_front();
         checks++; if (sent_words[i] !== w) $display("FAIL dedup_word%0d got %h want %h", i - n0, sent_words[i], w); else passes++;
      end
      checks++; if (level !== 4'd0) $display("FAIL dedup_level got %0d want 0", level); else passes++;

      busy_len = 30;
      base = $urandom;
      n0 = sent_words.size();
      push(base, 1'b0);
      wait_sends(n0 + 1, 10);
      w = exp_q.pop_front();
      checks++; if (sent_words.size() !== n0 + 1) $display("FAIL rst_first got %0d want %0d", sent_words.size(), n0 + 1); else passes++;
      push(base + 32'd5, 1'b0);
      push(base + 32'd9, 1'b0);
      steps(5);
      load_flag = ~load_flag;
      rst_n = 1'b0;
      step();
      checks++; if (tx_send !== 1'b0) $display("FAIL rst_tx_send got %b want 0", tx_send); else passes++;
      checks++; if (level !== 4'd0) $display("FAIL rst_level got %0d want 0", level); else passes++;
      checks++; if (drop_count !== 8'd0) $display("FAIL rst_drop got %0d want 0", drop_count); else passes++;
      exp_q.delete();
      exp_drop = 0;
      last_ok = 1'b0;
      rst_n = 1'b1;
      push(base + 32'd77, 1'b0);
      wait_sends(n0 + 2, 100);
      checks++; if (sent_words.size() !== n0 + 2) $display("FAIL rst_post_count got %0d want %0d", sent_words.size(), n0 + 2); else passes++;
      if (sent_words.size() == n0 + 2) begin
         w = exp_q.pop_front();
         checks++; if (sent_words[n0 + 1] !== w) $display("FAIL rst_post_word got %h want %h", sent_words[n0 + 1], w); else passes++;
         checks++; if (sent_gap[n0 + 1] < 1) $display("FAIL rst_post_gap got %0d want >=1", sent_gap[n0 + 1]); else passes++;
      end
      checks++; if (send_while_busy !== 0) $display("FAIL busy_send got %0d want 0", send_while_busy); else passes++;
      checks++; if (multi_send !== 0) $display("FAIL multi_send got %0d want 0", multi_send); else passes++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_flush();
      test_full_pop();
      test_drop_saturate();
      test_dedup_and_reset();
      steps(40);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
